ghost_mover: RTL and testbench
==============================

Name: ghost_mover

Overview:
- Next-generation ghost movement controller. Drives NUM_GHOSTS ghosts from one shared game FSM, instead of one fixed-direction ghost per instance.
- Each ghost has an autonomous direction register, chosen at every step tick from maze-legal moves, a preferred direction and a frightened-mode pseudo-random source.
- Sits between the maze collision logic (per-ghost legal-move enables) and the ghost position and sprite logic (step pulses and directions).

Parameters:
- NUM_GHOSTS, 4, number of ghosts; legal range 1..4.
- TICK_DIV, 8, clk cycles per movement tick; must be ≥2.
- FRIGHT_TICKS, 32, duration of frightened mode, counted in movement ticks.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start or restart request
- win  in  1  level, all pellets eaten
- lose  in  1  level, Pac-Man caught
- power  in  1  single-cycle pulse, power pellet eaten
- legal  in  4*NUM_GHOSTS  per-ghost legal moves; ghost g uses [4g+3:4g] = {up,down,right,left}
- pref_dir  in  2*NUM_GHOSTS  per-ghost targeting preference, same encoding as dir
- dir  out  2*NUM_GHOSTS  current heading per ghost; 0=up, 1=down, 2=right, 3=left
- step  out  NUM_GHOSTS  one-cycle pulse: move ghost g one cell in dir[g]
- hold  out  NUM_GHOSTS  ghost g is stationary
- frightened  out  1  frightened mode active
- state  out  2  0=IDLE, 1=RUN, 2=FRIGHT, 3=OVER

Behaviour:
- Reset values:
  - state=IDLE, every dir=up(0), step=0, hold=all 1, frightened=0.
  - Tick counter=0, fright counter=0, LFSR=8'hA5.
  - A reset asserted mid-operation takes effect on the next edge and overrides every other input.
- Game FSM, priority lose > win > power within a cycle:
  - IDLE: start → RUN. Otherwise stay; no steps.
  - RUN: lose or win → OVER. power → FRIGHT, load fright counter = FRIGHT_TICKS, every ghost reverses heading where the reverse is legal.
  - FRIGHT: lose or win → OVER. power → reload counter to FRIGHT_TICKS, no extra reversal. Counter decrements on each tick; on a tick where counter==1 → RUN.
  - OVER: start → IDLE. Steps are suppressed and dir is frozen.
- Tick counter:
  - Counts 0..TICK_DIV-1 in RUN and FRIGHT; held at 0 elsewhere.
  - Tick = counter==TICK_DIV-1.
  - In FRIGHT a ghost steps only on odd tick parity (a 1-bit toggle per tick), giving half speed.
- Direction selection per ghost, evaluated on a stepping tick, with rev = opposite of the current dir:
  1. If the candidate is legal and ≠ rev, take it. The candidate is pref_dir in RUN and LFSR bits [2g+1:2g] in FRIGHT.
  2. Otherwise keep the current dir if it is legal.
  3. Otherwise take the first legal non-reverse move in order up, down, right, left.
  4. Otherwise take rev if legal.
  5. Otherwise hold: no step pulse; hold[g]=1 and dir is unchanged.
- step[g] asserts in the same cycle the new dir registers visible (registered together, 1-cycle latency from the tick). hold[g]=1 in IDLE and OVER, and after a blocked evaluation until the next successful step.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Advances every cycle regardless of state; never all-zero.
- frightened = (state==FRIGHT).

Decomposition:
- Package ghost_pkg holds:
  - dir_t (2-bit enum UP, DOWN, RIGHT, LEFT) and game_state_t.
  - The legal-vector bit-position constants.
  - An opposite() function.
- Sub-module ghost_dir_sel: one instance per ghost via generate. It holds the dir and hold registers plus the selection priority logic and takes a tick-enable and a reverse-request.
- Top level owns the game FSM, tick/parity/fright counters and the LFSR.

Test Plan:
- Reset, then start. NUM_GHOSTS=4, TICK_DIV=8, all legal=4'b1111, pref=right → state=1 next cycle; first step pulse 8 cycles after entering RUN; all dir=2.
- Ghost 0 heading right, legal=4'b1000 (up only), pref=left → dir[0]=up with a step. Then legal=4'b0000 → step[0]=0, hold[0]=1, dir unchanged.
- Ghost 1 heading up, pref=down, legal=4'b1100 → keeps up (reverse rejected). Then legal=4'b0100 → dir=down (forced reversal).
- power pulse in RUN with ghosts heading right, legal all → every dir=left, frightened=1, steps every 16 cycles. A second power after 10 ticks extends FRIGHT to 42 ticks total before returning to state=1.
- lose and win asserted in the same cycle as power during RUN → state=3, frightened=0, no further steps. start → state=0.
- Assert reset during FRIGHT mid-tick → next cycle all outputs match the reset values and the LFSR reloads 8'hA5.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost movement controller.
// Direction encoding matches the dir output; legal vectors are {up,down,right,left}.
package ghost_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        RIGHT = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FRIGHT = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    localparam int LEGAL_UP    = 3;
    localparam int LEGAL_DOWN  = 2;
    localparam int LEGAL_RIGHT = 1;
    localparam int LEGAL_LEFT  = 0;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            RIGHT:   return LEFT;
            default: return RIGHT;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] legal, input dir_t d);
        case (d)
            UP:      return legal[LEGAL_UP];
            DOWN:    return legal[LEGAL_DOWN];
            RIGHT:   return legal[LEGAL_RIGHT];
            default: return legal[LEGAL_LEFT];
        endcase
    endfunction

endpackage

// File: rtl/ghost_dir_sel.sv
// Per-ghost heading register with the maze-aware direction priority.
// A reverse request flips the heading (if legal) without producing a step.
module ghost_dir_sel
    import ghost_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       step_en,
    input  logic       reverse_req,
    input  logic [3:0] legal,
    input  dir_t       cand,
    output dir_t       dir,
    output logic       step,
    output logic       hold
);

    dir_t dir_q;
    dir_t rev;
    dir_t pick;
    dir_t try_dir;
    logic found;
    logic step_q;
    logic hold_q;

    // Priority: candidate, keep heading, first non-reverse, reverse, else blocked.
    always_comb begin
        rev     = opposite(dir_q);
        pick    = dir_q;
        found   = 1'b0;
        try_dir = UP;
        if (is_legal(legal, cand) && cand != rev) begin
            pick  = cand;
            found = 1'b1;
        end else if (is_legal(legal, dir_q)) begin
            pick  = dir_q;
            found = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                try_dir = dir_t'(2'(i));
                if (!found && is_legal(legal, try_dir) && try_dir != rev) begin
                    pick  = try_dir;
                    found = 1'b1;
                end
            end
            if (!found && is_legal(legal, rev)) begin
                pick  = rev;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q  <= UP;
            step_q <= 1'b0;
            hold_q <= 1'b1;
        end else begin
            step_q <= 1'b0;
            if (!active) begin
                hold_q <= 1'b1;
            end else if (reverse_req) begin
                if (is_legal(legal, rev)) dir_q <= rev;
            end else if (step_en) begin
                if (found) begin
                    dir_q  <= pick;
                    step_q <= 1'b1;
                    hold_q <= 1'b0;
                end else begin
                    hold_q <= 1'b1;
                end
            end
        end
    end

    assign dir  = dir_q;
    assign step = step_q;
    assign hold = hold_q | ~active;

endmodule

// File: rtl/ghost_mover.sv
// Game FSM, movement tick divider, frightened timer and LFSR shared by all ghosts.
// Each ghost's heading and step pulse come from its own ghost_dir_sel instance.
module ghost_mover
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int TICK_DIV     = 8,
    parameter int FRIGHT_TICKS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    win,
    input  logic                    lose,
    input  logic                    power,
    input  logic [4*NUM_GHOSTS-1:0] legal,
    input  logic [2*NUM_GHOSTS-1:0] pref_dir,
    output logic [2*NUM_GHOSTS-1:0] dir,
    output logic [NUM_GHOSTS-1:0]   step,
    output logic [NUM_GHOSTS-1:0]   hold,
    output logic                    frightened,
    output logic [1:0]              state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int FW = $clog2(FRIGHT_TICKS + 1);

    game_state_t   state_q;
    game_state_t   state_d;
    logic [TW-1:0] tick_cnt;
    logic [FW-1:0] fright_cnt;
    logic [FW-1:0] fright_d;
    logic          parity;
    logic [7:0]    lfsr;
    logic          running;
    logic          tick;
    logic          ending;
    logic          step_en;
    logic          reverse_req;

    assign running     = (state_q == RUN) || (state_q == FRIGHT);
    assign tick        = running && (tick_cnt == TW'(TICK_DIV - 1));
    assign ending      = lose | win;
    // Frightened ghosts move on every other tick only.
    assign step_en     = tick && !ending && ((state_q == RUN) || ((state_q == FRIGHT) && parity));
    assign reverse_req = (state_q == RUN) && power && !ending;

    always_comb begin
        state_d  = state_q;
        fright_d = fright_cnt;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (ending) begin
                    state_d = OVER;
                end else if (power) begin
                    state_d  = FRIGHT;
                    fright_d = FW'(FRIGHT_TICKS);
                end
            end
            FRIGHT: begin
                if (ending) begin
                    state_d = OVER;
                end else if (power) begin
                    fright_d = FW'(FRIGHT_TICKS);
                end else if (tick) begin
                    if (fright_cnt == FW'(1)) begin
                        state_d  = RUN;
                        fright_d = '0;
                    end else begin
                        fright_d = fright_cnt - 1'b1;
                    end
                end
            end
            OVER: if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fright_cnt <= '0;
            tick_cnt   <= '0;
            parity     <= 1'b0;
            lfsr       <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            fright_cnt <= fright_d;
            tick_cnt   <= running ? (tick ? '0 : tick_cnt + 1'b1) : '0;
            parity     <= (state_q == FRIGHT) ? (tick ? ~parity : parity) : 1'b0;
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
        dir_t cand;
        dir_t ghost_dir;

        assign cand = (state_q == FRIGHT) ? dir_t'(lfsr[2*g+1 -: 2])
                                          : dir_t'(pref_dir[2*g+1 -: 2]);

        ghost_dir_sel u_sel (
            .clk         (clk),
            .reset       (reset),
            .active      (running),
            .step_en     (step_en),
            .reverse_req (reverse_req),
            .legal       (legal[4*g+3 -: 4]),
            .cand        (cand),
            .dir         (ghost_dir),
            .step        (step[g]),
            .hold        (hold[g])
        );

        assign dir[2*g+1 -: 2] = ghost_dir;
    end

    assign frightened = (state_q == FRIGHT);
    assign state      = state_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: FSM vector table, directed movement sequences and a
// randomized phase compared cycle by cycle against a behavioural game model.
`timescale 1ns/1ps
module tb_ghost_mover;

    localparam int NG = 4;
    localparam int TD = 8;
    localparam int FT = 32;

    logic            clk = 1'b0;
    logic            reset, start, win, lose, power;
    logic [4*NG-1:0] legal;
    logic [2*NG-1:0] pref_dir;
    logic [2*NG-1:0] dir;
    logic [NG-1:0]   step, hold;
    logic            frightened;
    logic [1:0]      state;

    ghost_mover #(.NUM_GHOSTS(NG), .TICK_DIV(TD), .FRIGHT_TICKS(FT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .win        (win),
        .lose       (lose),
        .power      (power),
        .legal      (legal),
        .pref_dir   (pref_dir),
        .dir        (dir),
        .step       (step),
        .hold       (hold),
        .frightened (frightened),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_st, m_tcnt, m_par, m_fcnt;
    logic [7:0] m_lfsr;
    int         m_dir[NG];
    bit         m_hold[NG];
    bit         m_step[NG];
    bit         chk_on = 0;
    int         opp[4] = '{1, 0, 3, 2};

    // legal nibble is {up,down,right,left}, so direction d lives at bit 3-d
    function automatic int pick_dir(input logic [3:0] lg, input int cand, input int cur);
        int rev;
        rev = opp[cur];
        if (lg[3-cand] && cand != rev) return cand;
        if (lg[3-cur]) return cur;
        for (int d = 0; d < 4; d++) if (lg[3-d] && d != rev) return d;
        if (lg[3-rev]) return rev;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] lg;
        int cand, nd;
        bit tk, ending, stepping;
        if (reset) begin
            m_st = 0; m_tcnt = 0; m_par = 0; m_fcnt = 0; m_lfsr = 8'hA5;
            for (int g = 0; g < NG; g++) begin
                m_dir[g] = 0; m_hold[g] = 1; m_step[g] = 0;
            end
        end else begin
            tk       = (m_st == 1 || m_st == 2) && m_tcnt == TD - 1;
            ending   = lose || win;
            stepping = tk && !ending && (m_st == 1 || (m_st == 2 && m_par == 1));
            for (int g = 0; g < NG; g++) begin
                m_step[g] = 0;
                lg = legal[4*g +: 4];
                if (m_st == 0 || m_st == 3) begin
                    m_hold[g] = 1;
                end else if (m_st == 1 && power && !ending) begin
                    if (lg[3-opp[m_dir[g]]]) m_dir[g] = opp[m_dir[g]];
                end else if (stepping) begin
                    cand = (m_st == 2) ? int'(m_lfsr[2*g +: 2]) : int'(pref_dir[2*g +: 2]);
                    nd = pick_dir(lg, cand, m_dir[g]);
                    if (nd < 0) m_hold[g] = 1;
                    else begin
                        m_dir[g] = nd; m_step[g] = 1; m_hold[g] = 0;
                    end
                end
            end
            if (m_st == 2) begin
                if (tk) m_par = 1 - m_par;
            end else m_par = 0;
            m_tcnt = (m_st == 1 || m_st == 2) ? (tk ? 0 : m_tcnt + 1) : 0;
            case (m_st)
                0: if (start) m_st = 1;
                1: if (ending) m_st = 3;
                   else if (power) begin m_st = 2; m_fcnt = FT; end
                2: if (ending) m_st = 3;
                   else if (power) m_fcnt = FT;
                   else if (tk) begin
                       if (m_fcnt == 1) begin m_st = 1; m_fcnt = 0; end
                       else m_fcnt = m_fcnt - 1;
                   end
                default: if (start) m_st = 0;
            endcase
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
        end
    end

    always @(negedge clk) begin : model_cmp
        logic [2*NG-1:0] ed;
        logic [NG-1:0]   es, eh;
        if (chk_on) begin
            for (int g = 0; g < NG; g++) begin
                ed[2*g +: 2] = 2'(m_dir[g]);
                es[g] = m_step[g];
                eh[g] = m_hold[g] | (m_st == 0 || m_st == 3);
            end
            check("model", 32'({state, frightened, hold, step, dir}),
                  32'({2'(m_st), m_st == 2, eh, es, ed}));
        end
    end

    // ---------------- FSM vector table ----------------
    typedef struct {
        logic       st, wn, ls, pw;
        logic [1:0] exp_state;
        logic       exp_fr;
        logic [3:0] exp_hold;
    } vec_t;

    vec_t vecs[12];
    int   first_step, n_steps, late_steps;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_dir"}, 32'(dir), 32'd0);
        check({tag, "_step"}, 32'(step), 32'd0);
        check({tag, "_hold"}, 32'(hold), 32'hF);
        check({tag, "_fright"}, 32'(frightened), 32'd0);
    endtask

    initial begin
        reset = 1; start = 0; win = 0; lose = 0; power = 0;
        legal = '1; pref_dir = 8'hAA;
        vecs[0]  = '{0, 0, 0, 0, 2'd0, 1'b0, 4'hF};
        vecs[1]  = '{1, 0, 0, 0, 2'd1, 1'b0, 4'hF};
        vecs[2]  = '{0, 0, 0, 1, 2'd2, 1'b1, 4'hF};
        vecs[3]  = '{0, 0, 0, 1, 2'd2, 1'b1, 4'hF};
        vecs[4]  = '{0, 1, 0, 1, 2'd3, 1'b0, 4'hF};
        vecs[5]  = '{0, 0, 0, 0, 2'd3, 1'b0, 4'hF};
        vecs[6]  = '{0, 0, 1, 0, 2'd3, 1'b0, 4'hF};
        vecs[7]  = '{1, 0, 0, 0, 2'd0, 1'b0, 4'hF};
        vecs[8]  = '{0, 1, 0, 0, 2'd0, 1'b0, 4'hF};
        vecs[9]  = '{1, 0, 1, 0, 2'd1, 1'b0, 4'hF};
        vecs[10] = '{0, 0, 1, 0, 2'd3, 1'b0, 4'hF};
        vecs[11] = '{1, 0, 0, 0, 2'd0, 1'b0, 4'hF};

        cyc(1);
        chk_on = 1;
        cyc(1);
        reset = 0;
        check_reset_vals("reset");

        foreach (vecs[i]) begin
            start = vecs[i].st; win = vecs[i].wn; lose = vecs[i].ls; power = vecs[i].pw;
            cyc(1);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_fright", i), 32'(frightened), 32'(vecs[i].exp_fr));
            check($sformatf("vec%0d_hold", i), 32'(hold), 32'(vecs[i].exp_hold));
        end
        start = 0; win = 0; lose = 0; power = 0;

        // fresh game from reset: first step 8 cycles after entering RUN
        reset = 1;
        cyc(1);
        reset = 0;
        check_reset_vals("reset2");
        legal = '1; pref_dir = 8'hAA; start = 1;
        cyc(1);
        start = 0;
        check("run_entry", 32'(state), 32'd1);
        cyc(7);
        check("no_early_step", 32'(step), 32'd0);
        cyc(1);
        check("first_step", 32'(step), 32'hF);
        check("first_dir", 32'(dir), 32'hAA);
        check("first_hold", 32'(hold), 32'd0);

        // ghost 0: only up is open, preference is the reverse
        legal[3:0] = 4'b1000; pref_dir[1:0] = 2'd3;
        cyc(8);
        check("g0_up_step", 32'(step[0]), 32'd1);
        check("g0_up_dir", 32'(dir[1:0]), 32'd0);
        legal[3:0] = 4'b0000;
        cyc(8);
        check("g0_blk_step", 32'(step), 32'hE);
        check("g0_blk_hold", 32'(hold[0]), 32'd1);
        check("g0_blk_dir", 32'(dir[1:0]), 32'd0);

        // ghost 1: turn up, reject reverse, then forced reverse
        pref_dir[3:2] = 2'd0;
        cyc(8);
        check("g1_turn_up", 32'(dir[3:2]), 32'd0);
        pref_dir[3:2] = 2'd1; legal[7:4] = 4'b1100;
        cyc(8);
        check("g1_keep_up", 32'({step[1], dir[3:2]}), 32'h4);
        legal[7:4] = 4'b0100;
        cyc(8);
        check("g1_forced_rev", 32'({step[1], dir[3:2]}), 32'h5);

        // everyone heads right, then a power pellet
        legal = '1; pref_dir = 8'hAA;
        cyc(8);
        check("all_right_dir", 32'(dir), 32'hAA);
        check("all_right_step", 32'(step), 32'hF);
        power = 1;
        first_step = -1; n_steps = 0; late_steps = 0;
        for (int j = 1; j <= 336; j++) begin
            cyc(1);
            if (j == 1) begin
                check("fright_state", 32'(state), 32'd2);
                check("fright_flag", 32'(frightened), 32'd1);
                check("fright_rev", 32'(dir), 32'hFF);
                check("fright_nostep", 32'(step), 32'd0);
            end
            if (step[0] && j <= 80) begin
                n_steps++;
                if (first_step < 0) first_step = j;
            end
            if (j == 335) check("fright_still", 32'(state), 32'd2);
            if (j == 336) begin
                check("fright_done", 32'(state), 32'd1);
                check("fright_flag_off", 32'(frightened), 32'd0);
            end
            power = (j == 80);
        end
        check("half_speed_first", 32'(first_step), 32'd16);
        check("half_speed_count", 32'(n_steps), 32'd5);

        // lose and win together with power
        power = 1; lose = 1; win = 1;
        cyc(1);
        power = 0; lose = 0; win = 0;
        check("over_state", 32'(state), 32'd3);
        check("over_fright", 32'(frightened), 32'd0);
        check("over_hold", 32'(hold), 32'hF);
        for (int j = 0; j < 20; j++) begin
            cyc(1);
            if (step != '0) late_steps++;
        end
        check("over_no_steps", 32'(late_steps), 32'd0);
        start = 1;
        cyc(1);
        check("over_to_idle", 32'(state), 32'd0);
        cyc(1);
        check("idle_to_run", 32'(state), 32'd1);
        start = 0; power = 1;
        cyc(1);
        power = 0;
        cyc(5);
        check("pre_reset_fright", 32'(state), 32'd2);
        reset = 1;
        cyc(1);
        reset = 0;
        check_reset_vals("mid_reset");

        // randomized play against the model
        for (int j = 0; j < 5000; j++) begin
            reset    = ($urandom_range(0, 999) == 0);
            start    = ($urandom_range(0, 19) == 0);
            win      = ($urandom_range(0, 799) == 0);
            lose     = ($urandom_range(0, 799) == 0);
            power    = ($urandom_range(0, 99) == 0);
            legal    = 16'($urandom) | ($urandom_range(0, 1) ? 16'h0000 : 16'h5A5A);
            pref_dir = 8'($urandom);
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
